// File: rtl/packet_engine_pkg.sv
// packet_engine_pkg: opcodes, header size and state/error encodings for packet_engine
package packet_engine_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD = 8'hA0;
  localparam logic [7:0] OP_MUL = 8'hA1;
  localparam int HDR_BYTES = 4;
  typedef enum logic [2:0] {HDR_OP, HDR_RSV, HDR_LLSB, HDR_LMSB, ECHO, ACCUM, RESULT, DRAIN} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_OPCODE} err_t;
endpackage

// File: rtl/pkt_alu_accum.sv
// pkt_alu_accum: LSB-first operand assembly, add/mul accumulation and result byte shift-out
module pkt_alu_accum #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mul,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       shift,
  output logic [7:0] first_byte,
  output logic [7:0] next_byte
);
  localparam int NB = OPERAND_WIDTH / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  logic [IW-1:0] idx;
  logic first;
  logic [OPERAND_WIDTH-1:0] op, acc, res, op_full, acc_n;
  logic op_done;
  assign op_full = op | (OPERAND_WIDTH'(in_data) << {idx, 3'b000});
  assign acc_n = first ? op_full : mul ? acc * op_full : acc + op_full;
  assign op_done = idx == IW'(NB - 1);
  assign first_byte = acc_n[7:0];
  assign next_byte = res[7:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      first <= 1'b1;
      op <= '0;
      acc <= '0;
      res <= '0;
    end else if (start) begin
      idx <= '0;
      first <= 1'b1;
      op <= '0;
    end else if (in_valid) begin
      if (op_done) begin
        idx <= '0;
        op <= '0;
        first <= 1'b0;
        acc <= acc_n;
        res <= acc_n >> 8;
      end else begin
        idx <= idx + 1'b1;
        op <= op_full;
      end
    end else if (shift) begin
      res <= res >> 8;
    end
  end
endmodule

// File: rtl/packet_engine.sv
// packet_engine: framed packet parser executing echo/add/mul and streaming the response
module packet_engine
  import packet_engine_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter logic [15:0] MAX_LENGTH = 16'd1028
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);
  localparam int NB = OPERAND_WIDTH / 8;
  state_t state, state_n;
  err_t err_code, err_code_n;
  logic [15:0] cnt, cnt_n, len, pay;
  logic [7:0] opcode, opcode_n, len_lsb, len_lsb_n, tx_data_n, first_byte, next_byte;
  logic tx_valid_n, err_n, rx_hs, tx_hs, last, arith;
  assign rx_ready_o = state == HDR_OP ? !tx_valid_o : state == ECHO ? (!tx_valid_o || tx_ready_i) : state != RESULT;
  assign rx_hs = rx_valid_i && rx_ready_o;
  assign tx_hs = tx_valid_o && tx_ready_i;
  assign len = {rx_data_i, len_lsb};
  assign pay = len - 16'(HDR_BYTES);
  assign last = cnt == 16'd1;
  assign arith = opcode == OP_ADD || opcode == OP_MUL;
  assign busy_o = state != HDR_OP || tx_valid_o;
  assign err_code_o = err_code;
  pkt_alu_accum #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_alu (
    .clk(clk_i),
    .rst(rst_i),
    .start(state == HDR_LMSB && rx_hs),
    .mul(opcode == OP_MUL),
    .in_valid(state == ACCUM && rx_hs),
    .in_data(rx_data_i),
    .shift(state == RESULT && tx_hs && cnt != 16'd0),
    .first_byte(first_byte),
    .next_byte(next_byte)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    opcode_n = opcode;
    len_lsb_n = len_lsb;
    tx_data_n = tx_data_o;
    tx_valid_n = tx_valid_o && !tx_ready_i;
    err_n = 1'b0;
    err_code_n = err_code;
    case (state)
      HDR_OP: if (rx_hs) begin
        opcode_n = rx_data_i;
        state_n = HDR_RSV;
      end
      HDR_RSV: if (rx_hs) state_n = HDR_LLSB;
      HDR_LLSB: if (rx_hs) begin
        len_lsb_n = rx_data_i;
        state_n = HDR_LMSB;
      end
      HDR_LMSB: if (rx_hs) begin
        cnt_n = pay;
        if (len < 16'(HDR_BYTES) || len > MAX_LENGTH) begin
          err_n = 1'b1;
          err_code_n = ERR_LEN;
          state_n = len > 16'(HDR_BYTES) ? DRAIN : HDR_OP;
        end else if (opcode == OP_ECHO) begin
          state_n = pay == 16'd0 ? HDR_OP : ECHO;
        end else if (arith && pay != 16'd0 && pay % 16'(NB) == 16'd0) begin
          state_n = ACCUM;
        end else begin
          err_n = 1'b1;
          err_code_n = arith ? ERR_LEN : ERR_OPCODE;
          state_n = pay == 16'd0 ? HDR_OP : DRAIN;
        end
      end
      ECHO: if (rx_hs) begin
        tx_data_n = rx_data_i;
        tx_valid_n = 1'b1;
        cnt_n = cnt - 16'd1;
        state_n = last ? HDR_OP : ECHO;
      end
      ACCUM: if (rx_hs) begin
        cnt_n = last ? 16'(NB - 1) : cnt - 16'd1;
        tx_data_n = last ? first_byte : tx_data_o;
        tx_valid_n = last || tx_valid_n;
        state_n = last ? RESULT : ACCUM;
      end
      RESULT: if (tx_hs) begin
        state_n = cnt == 16'd0 ? HDR_OP : RESULT;
        tx_data_n = cnt == 16'd0 ? tx_data_o : next_byte;
        tx_valid_n = cnt != 16'd0;
        cnt_n = cnt == 16'd0 ? cnt : cnt - 16'd1;
      end
      DRAIN: if (rx_hs) begin
        cnt_n = cnt - 16'd1;
        state_n = last ? HDR_OP : DRAIN;
      end
      default: state_n = HDR_OP;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= HDR_OP;
      cnt <= '0;
      opcode <= '0;
      len_lsb <= '0;
      tx_data_o <= '0;
      tx_valid_o <= 1'b0;
      err_o <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      opcode <= opcode_n;
      len_lsb <= len_lsb_n;
      tx_data_o <= tx_data_n;
      tx_valid_o <= tx_valid_n;
      err_o <= err_n;
      err_code <= err_code_n;
    end
  end
endmodule

// File: tb/tb_packet_engine.sv
// tb_packet_engine: directed packets with a queue scoreboard checked by an independent tx/err monitor
module tb_packet_engine;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_ready_o;
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i = 1'b1;
  logic busy_o;
  logic err_o;
  logic [1:0] err_code_o;
  int total = 0;
  int bad = 0;
  logic alt = 1'b0;
  logic bp = 1'b0;
  logic [7:0] tx_q[$];
  logic [1:0] err_q[$];
  packet_engine dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o(busy_o),
    .err_o(err_o),
    .err_code_o(err_code_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want none", name, act);
  endtask
  initial forever begin
    @(negedge clk_i);
    tx_ready_i = alt ? ~tx_ready_i : 1'b1;
  end
  initial forever begin
    @(negedge clk_i);
    #2;
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) begin
        if (tx_q.size() == 0) fail("tx_unexpected", tx_data_o);
        else chk("tx_data", tx_data_o, tx_q.pop_front());
      end
      if (err_o) begin
        if (err_q.size() == 0) fail("err_unexpected", err_code_o);
        else chk("err_code", err_code_o, err_q.pop_front());
      end
    end
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    #1;
    while (!rx_ready_o && n < 500) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 500) fail("rx_timeout", b);
    if (bp) chk("rx_ready_stall", tx_valid_o && !tx_ready_i, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask
  task automatic hdr(input logic [7:0] op, input logic [15:0] len);
    send(op);
    send(8'h00);
    send(len[7:0]);
    send(len[15:8]);
  endtask
  task automatic operand(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send(v[8*i +: 8]);
  endtask
  task automatic expect_res(input logic [31:0] v);
    for (int i = 0; i < 4; i++) tx_q.push_back(v[8*i +: 8]);
  endtask
  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || tx_valid_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) fail("drain_timeout", tx_q.size());
  endtask
  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_code", err_code_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rx_ready", rx_ready_o, 1);
    @(negedge clk_i);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    hdr(8'hEC, 16'd7);
    send(8'h11);
    chk("echo_lat0", {tx_valid_o, tx_data_o}, 9'h111);
    send(8'h22);
    chk("echo_lat1", {tx_valid_o, tx_data_o}, 9'h122);
    send(8'h33);
    chk("echo_lat2", {tx_valid_o, tx_data_o}, 9'h133);
    expect_res(32'h0000_0000);
    hdr(8'hA0, 16'd12);
    operand(32'h0000_0001);
    operand(32'hFFFF_FFFF);
    chk("add_first_lat", {tx_valid_o, tx_data_o}, 9'h100);
    chk("add_busy", busy_o, 1);
    expect_res(32'h0000_0069);
    hdr(8'hA1, 16'd16);
    operand(32'd3);
    operand(32'd5);
    operand(32'd7);
    chk("mul_first_lat", {tx_valid_o, tx_data_o}, 9'h169);
    drain();
    err_q.push_back(2'd2);
    hdr(8'h55, 16'd6);
    send(8'hAA);
    send(8'hBB);
    chk("badop_no_tx", tx_valid_o, 0);
    chk("badop_code_hold", err_code_o, 2);
    tx_q.push_back(8'h5A);
    hdr(8'hEC, 16'd5);
    send(8'h5A);
    err_q.push_back(2'd1);
    hdr(8'hEC, 16'd3);
    chk("short_code", err_code_o, 1);
    err_q.push_back(2'd2);
    hdr(8'h11, 16'd5);
    send(8'h77);
    tx_q.push_back(8'h3C);
    hdr(8'hEC, 16'd5);
    send(8'h3C);
    err_q.push_back(2'd1);
    hdr(8'hA0, 16'd6);
    send(8'h01);
    send(8'h02);
    chk("add_len_no_tx", tx_valid_o, 0);
    err_q.push_back(2'd1);
    hdr(8'hEC, 16'h0405);
    for (int i = 0; i < 1025; i++) send(8'hE7);
    chk("maxlen_no_tx", tx_valid_o, 0);
    tx_q.push_back(8'h99);
    hdr(8'hEC, 16'd5);
    send(8'h99);
    drain();
    alt = 1'b1;
    for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
    hdr(8'hEC, 16'd8);
    bp = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i));
    bp = 1'b0;
    drain();
    alt = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    tx_q.push_back(8'hD1);
    hdr(8'hEC, 16'd7);
    send(8'hD1);
    send(8'hD2);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid_o, 0);
    chk("midrst_err_code", err_code_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(negedge clk_i);
    expect_res(32'h0000_0100);
    hdr(8'hA0, 16'd12);
    operand(32'h0000_00FF);
    operand(32'h0000_0001);
    drain();
    repeat (5) @(negedge clk_i);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    chk("end_busy", busy_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
